// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply-unit controller.
// Holds the op encodings, the controller state enum, the watchdog default
// and the op classification helper.
// Optional feature macro: MDU_MADD_EN (when defined, ops 1xx MADD/MADDU/MSUB/MSUBU
// are treated as accumulating multiplies).
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MTHI  = 3'b010;
  localparam logic [2:0] OP_MTLO  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MADDU = 3'b101;
  localparam logic [2:0] OP_MSUB  = 3'b110;
  localparam logic [2:0] OP_MSUBU = 3'b111;

  localparam int MUL_TIMEOUT_DEFAULT = 40;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } state_t;

  // True when the op starts a multiply (plain or accumulating).
  function automatic logic op_is_mul(input logic [2:0] op_code);
`ifdef MDU_MADD_EN
    return (op_code != OP_MTHI) && (op_code != OP_MTLO);
`else
    return (op_code == OP_MULT) || (op_code == OP_MULTU);
`endif
  endfunction

endpackage

// File: rtl/hilo_regs.sv
// hilo_regs: HI/LO register pair with independent write enables per half.
// Reset clears both halves.
module hilo_regs (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] wr_data,
  input  logic        wr_hi,
  input  logic        wr_lo,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // HI half: loaded from the upper word of the write data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= 32'd0;
    end else if (wr_hi) begin
      hi <= wr_data[63:32];
    end
  end

  // LO half: loaded from the lower word of the write data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lo <= 32'd0;
    end else if (wr_lo) begin
      lo <= wr_data[31:0];
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: EX-stage controller for the multi-cycle multiplier.
// Accepts MULT/MULTU/MTHI/MTLO, latches operands, pulses mul_start, waits for
// the multiplier and writes the 64-bit product into HI/LO. A watchdog aborts a
// multiply whose busy never drops and raises a sticky err flag.
// Optional feature macro: MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU, which add or
// subtract the product to/from {hi,lo} at writeback.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_TIMEOUT = MUL_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mf_req,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        err,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_sign,
  output logic        mul_start,
  input  logic        mul_busy,
  input  logic [63:0] mul_z
);

  localparam int CW = $clog2(MUL_TIMEOUT + 1);
  // Last WAIT cycle allowed before the watchdog fires.
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic [63:0]   wb_data;
  logic [63:0]   wr_data;
  logic          wr_hi;
  logic          wr_lo;

  assign accept = op_valid && (state == IDLE);

  // Only instructions that touch the MDU wait on it; everything else flows.
  assign stall = (state != IDLE) && (op_valid || mf_req);

`ifdef MDU_MADD_EN
  logic acc_mode;
  logic acc_sub;

  // Remember whether the accepted multiply accumulates, and in which direction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_mode <= 1'b0;
      acc_sub  <= 1'b0;
    end else if (accept && op_is_mul(op)) begin
      acc_mode <= op[2];
      acc_sub  <= op[1];
    end
  end

  // Writeback value: raw product or {hi,lo} +/- product, wrapping mod 2^64
  always_comb begin
    wb_data = mul_z;
    if (acc_mode) begin
      if (acc_sub) begin
        wb_data = {hi, lo} - mul_z;
      end else begin
        wb_data = {hi, lo} + mul_z;
      end
    end else begin
      wb_data = mul_z;
    end
  end
`else
  assign wb_data = mul_z;
`endif

  // HI/LO write port control: MTHI/MTLO in IDLE, full 64-bit write in WB
  always_comb begin
    wr_data = 64'd0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    case (state)
      IDLE: begin
        if (accept && (op == OP_MTHI)) begin
          wr_data = {rs_val, 32'd0};
          wr_hi   = 1'b1;
        end else if (accept && (op == OP_MTLO)) begin
          wr_data = {32'd0, rs_val};
          wr_lo   = 1'b1;
        end else begin
          wr_hi   = 1'b0;
          wr_lo   = 1'b0;
        end
      end
      WB: begin
        wr_data = wb_data;
        wr_hi   = 1'b1;
        wr_lo   = 1'b1;
      end
      default: begin
        wr_hi = 1'b0;
        wr_lo = 1'b0;
      end
    endcase
  end

  // Controller FSM with operand latches, start pulse and watchdog
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mul_a     <= 32'd0;
      mul_b     <= 32'd0;
      mul_sign  <= 1'b0;
      mul_start <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mul_start <= 1'b0;
          if (accept && op_is_mul(op)) begin
            mul_a     <= rs_val;
            mul_b     <= rt_val;
            mul_sign  <= ~op[0];
            mul_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mul_start <= 1'b0;
          cnt       <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          mul_start <= 1'b0;
          cnt       <= cnt + CW'(1);
          if (!mul_busy) begin
            state <= WB;
          end else if (cnt == CNT_LAST) begin
            // Multiplier never finished: abandon the op without writing HI/LO.
            err   <= 1'b1;
            state <= IDLE;
          end
        end
        WB: begin
          mul_start <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          mul_start <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  hilo_regs u_hilo (
    .clk     (clk),
    .reset   (reset),
    .wr_data (wr_data),
    .wr_hi   (wr_hi),
    .wr_lo   (wr_lo),
    .hi      (hi),
    .lo      (lo)
  );

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl. A behavioural
// multiplier answers mul_start with a few busy cycles; a stuck flag turns it
// into a stub that never drops busy.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mf_req;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        err;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_sign;
  logic        mul_start;
  logic        mul_busy;
  logic [63:0] mul_z;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int MLAT = 3;
  logic stuck;
  int   mcnt;

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .mf_req    (mf_req),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo),
    .err       (err),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_sign  (mul_sign),
    .mul_start (mul_start),
    .mul_busy  (mul_busy),
    .mul_z     (mul_z)
  );

  function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = s ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  // Multiplier model: busy from the edge after mul_start for MLAT+1 cycles
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_busy <= 1'b0;
      mul_z    <= 64'd0;
      mcnt     <= 0;
    end else if (mul_start) begin
      mul_busy <= 1'b1;
      mcnt     <= MLAT;
      mul_z    <= mul_ref(mul_a, mul_b, mul_sign);
    end else if (mul_busy && !stuck) begin
      if (mcnt == 0) mul_busy <= 1'b0;
      else mcnt <= mcnt - 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op       = o;
    rs_val   = a;
    rt_val   = b;
    step();
    op_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int cycles;
    cycles = 0;
    mf_req = 1'b1;
    #1;
    while (stall && cycles < 200) begin
      step();
      cycles++;
    end
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle: stall=%b after %0d cycles, required 0", stall, cycles);
    end
    mf_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; op_valid = 1'b1; op = OP_MTHI; rs_val = 32'hDEADBEEF;
    rt_val = 32'd0; mf_req = 1'b1; stuck = 1'b0;
    step(); step();
    n_tests++;
    if ({hi, lo, mul_a, mul_b} !== 128'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got %h, required 0", {hi, lo, mul_a, mul_b});
    end
    n_tests++;
    if ({err, mul_sign, mul_start, stall} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: err/sign/start/stall=%b, required 0000",
               {err, mul_sign, mul_start, stall});
    end
    reset = 1'b0; op_valid = 1'b0; mf_req = 1'b0;
    step();
  endtask

  task automatic test_mult();
    int starts;
    send(OP_MULT, 32'hFFFFFFFF, 32'h00000002);
    n_tests++;
    if ({mul_sign, mul_a, mul_b} !== {1'b1, 32'hFFFFFFFF, 32'h00000002}) begin
      n_fail++;
      $display("FAIL mult_latch: sign/a/b=%h, required 1/ffffffff/00000002",
               {mul_sign, mul_a, mul_b});
    end
    starts = 0;
    for (int i = 0; i < 12; i++) begin
      if (mul_start === 1'b1) starts++;
      step();
    end
    n_tests++;
    if (starts != 1) begin
      n_fail++;
      $display("FAIL mult_start_pulse: high for %0d cycles, required 1", starts);
    end
    wait_idle();
    n_tests++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFE) begin
      n_fail++;
      $display("FAIL mult_result: hi:lo=%h, required ffffffff_fffffffe", {hi, lo});
    end
  endtask

  task automatic test_multu();
    send(OP_MULTU, 32'hFFFFFFFF, 32'h00000002);
    n_tests++;
    if (mul_sign !== 1'b0) begin
      n_fail++;
      $display("FAIL multu_sign: mul_sign=%b, required 0", mul_sign);
    end
    wait_idle();
    n_tests++;
    if ({hi, lo} !== 64'h00000001_FFFFFFFE) begin
      n_fail++;
      $display("FAIL multu_result: hi:lo=%h, required 00000001_fffffffe", {hi, lo});
    end
  endtask

  task automatic test_mf_stall();
    int cycles;
    send(OP_MULT, 32'h00030000, 32'h00020000);
    step();
    mf_req = 1'b0;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL unrelated_no_stall: stall=%b, required 0", stall);
    end
    mf_req = 1'b1;
    #1;
    n_tests++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL mfhi_stall: stall=%b, required 1", stall);
    end
    cycles = 0;
    while (stall && cycles < 50) begin
      step();
      cycles++;
    end
    n_tests++;
    if ((stall !== 1'b0) || (cycles == 0)) begin
      n_fail++;
      $display("FAIL mfhi_release: stall=%b after %0d cycles, required 0 after >0", stall, cycles);
    end
    n_tests++;
    if ({hi, lo} !== 64'h00000006_00000000) begin
      n_fail++;
      $display("FAIL mfhi_value: hi:lo=%h, required 00000006_00000000", {hi, lo});
    end
    mf_req = 1'b0;
  endtask

  task automatic test_mthi();
    op_valid = 1'b1; op = OP_MTHI; rs_val = 32'h12345678;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL mthi_stall: stall=%b, required 0", stall);
    end
    step();
    op_valid = 1'b0;
    n_tests++;
    if ({hi, lo, stall} !== {32'h12345678, 32'h00000000, 1'b0}) begin
      n_fail++;
      $display("FAIL mthi_value: hi/lo/stall=%h, required 12345678/00000000/0", {hi, lo, stall});
    end
    send(OP_MTLO, 32'hCAFEF00D, 32'd0);
    n_tests++;
    if ({hi, lo} !== 64'h12345678_CAFEF00D) begin
      n_fail++;
      $display("FAIL mtlo_value: hi:lo=%h, required 12345678_cafef00d", {hi, lo});
    end
  endtask

  task automatic test_back_to_back();
    int cycles;
    send(OP_MULTU, 32'd2, 32'd3);
    op_valid = 1'b1; op = OP_MTHI; rs_val = 32'hAAAA0000;
    #1;
    n_tests++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_held_stall: stall=%b, required 1", stall);
    end
    cycles = 0;
    while (stall && cycles < 50) begin
      step();
      cycles++;
    end
    step();
    op_valid = 1'b0;
    n_tests++;
    if ({hi, lo} !== 64'hAAAA0000_00000006) begin
      n_fail++;
      $display("FAIL b2b_value: hi:lo=%h, required aaaa0000_00000006", {hi, lo});
    end
  endtask

  task automatic test_watchdog();
    stuck = 1'b1;
    send(OP_MULT, 32'd2, 32'd3);
    repeat (40) step();
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL wdog_early: err=%b before timeout, required 0", err);
    end
    step();
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL wdog_fire: err=%b after 40 WAIT cycles, required 1", err);
    end
    n_tests++;
    if ({hi, lo} !== 64'hAAAA0000_00000006) begin
      n_fail++;
      $display("FAIL wdog_nowrite: hi:lo=%h, required aaaa0000_00000006", {hi, lo});
    end
    stuck = 1'b0;
    send(OP_MULT, 32'd7, 32'd8);
    wait_idle();
    n_tests++;
    if ({err, hi, lo} !== {1'b1, 64'd56}) begin
      n_fail++;
      $display("FAIL wdog_recover: err/hi:lo=%h, required 1/56", {err, hi, lo});
    end
  endtask

  task automatic test_reset_mid();
    stuck = 1'b1;
    send(OP_MULT, 32'd5, 32'd5);
    repeat (5) step();
    reset = 1'b1; mf_req = 1'b1;
    #1;
    n_tests++;
    if ({hi, lo, mul_a, mul_b, err, mul_sign, mul_start, stall} !== 132'd0) begin
      n_fail++;
      $display("FAIL reset_mid: outputs=%h, required 0",
               {hi, lo, mul_a, mul_b, err, mul_sign, mul_start, stall});
    end
    step();
    reset = 1'b0; stuck = 1'b0;
    #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: stall=%b with mf_req, required 0", stall);
    end
    mf_req = 1'b0;
  endtask

  task automatic test_madd();
    send(OP_MTHI, 32'd0, 32'd0);
    send(OP_MTLO, 32'd5, 32'd0);
`ifdef MDU_MADD_EN
    send(OP_MADD, 32'd3, 32'd4);
    wait_idle();
    n_tests++;
    if ({hi, lo} !== 64'd17) begin
      n_fail++;
      $display("FAIL madd_value: hi:lo=%h, required 00000000_00000011", {hi, lo});
    end
    send(OP_MSUB, 32'd1, 32'd20);
    wait_idle();
    n_tests++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin
      n_fail++;
      $display("FAIL msub_value: hi:lo=%h, required ffffffff_fffffffd", {hi, lo});
    end
`else
    for (int i = 0; i < 4; i++) begin
      op_valid = 1'b1; op = 3'(4 + i); rs_val = 32'd3; rt_val = 32'd4;
      step();
      n_tests++;
      if ({stall, mul_start} !== 2'b00) begin
        n_fail++;
        $display("FAIL madd_ignored op=%b: stall/start=%b, required 00", op, {stall, mul_start});
      end
    end
    op_valid = 1'b0;
    repeat (8) step();
    n_tests++;
    if ({hi, lo} !== 64'd5) begin
      n_fail++;
      $display("FAIL madd_nowrite: hi:lo=%h, required 00000000_00000005", {hi, lo});
    end
`endif
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_mf_stall();
    test_mthi();
    test_back_to_back();
    test_watchdog();
    test_reset_mid();
    test_madd();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
